// File: rtl/sprite_pkg.sv
// Shared screen geometry, FSM encoding and the axis clamp helper for sprite_motion_ctrl.
package sprite_pkg;

  localparam int SCREEN_W = 1280;
  localparam int SCREEN_H = 720;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_CLAMP,
    S_COMMIT
  } state_t;

  typedef struct packed {
    logic [11:0] val;
    logic        hit;
  } clamp_t;

  // Limits a signed coordinate to [0, hi]; hit flags that a limit was applied.
  function automatic clamp_t clamp_axis(input logic signed [11:0] v,
                                        input logic signed [11:0] hi);
    clamp_t r;
    r.hit = 1'b1;
    if (v < 0)       r.val = '0;
    else if (v > hi) r.val = hi;
    else begin
      r.val = v;
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/vblank_detect.sv
// Registered frame-edge detector: pulses one cycle after the raster reaches (0, SCREEN_H).
module vblank_detect
  import sprite_pkg::*;
(
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        edge_out
);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) edge_out <= 1'b0;
    else        edge_out <= (hcount_in == 11'd0) && (vcount_in == 10'(SCREEN_H));
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position update: velocity step, screen clamp, tear-free commit in vblank.
// Define SPRITE_BOUNCE_EN to reflect (negate) a clamped velocity component instead of zeroing it.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int X_INIT = 0,
  parameter int Y_INIT = 0
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [10:0] req_x_in,
  input  logic [9:0]  req_y_in,
  input  logic        vel_valid_in,
  input  logic [3:0]  vel_dx_in,
  input  logic [3:0]  vel_dy_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        frame_update_out
);

  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - WIDTH);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - HEIGHT);

  state_t             state;
  logic               frame_edge;
  logic signed [3:0]  dx, dy;
  logic               pending, ready_q;
  logic [10:0]        px;
  logic [9:0]         py;
  logic signed [11:0] cand_x, cand_y;
  clamp_t             cx, cy, req_cx, req_cy;

  vblank_detect u_vblank (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .edge_out     (frame_edge)
  );

  assign req_ready_out = ready_q & ~pending;
  assign req_cx = clamp_axis({1'b0, px}, X_MAX);
  assign req_cy = clamp_axis({2'b0, py}, Y_MAX);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= S_IDLE;
      x_out            <= 11'(X_INIT);
      y_out            <= 10'(Y_INIT);
      dx               <= '0;
      dy               <= '0;
      pending          <= 1'b0;
      ready_q          <= 1'b0;
      px               <= '0;
      py               <= '0;
      cand_x           <= '0;
      cand_y           <= '0;
      cx               <= '0;
      cy               <= '0;
      frame_update_out <= 1'b0;
    end else begin
      ready_q          <= 1'b1;
      frame_update_out <= 1'b0;
      case (state)
        S_IDLE: if (frame_edge) state <= S_STEP;
        S_STEP: begin
          cand_x <= $signed({1'b0, x_out}) + {{8{dx[3]}}, dx};
          cand_y <= $signed({2'b0, y_out}) + {{8{dy[3]}}, dy};
          state  <= S_CLAMP;
        end
        S_CLAMP: begin
          cx    <= clamp_axis(cand_x, X_MAX);
          cy    <= clamp_axis(cand_y, Y_MAX);
          state <= S_COMMIT;
        end
        S_COMMIT: begin
          frame_update_out <= 1'b1;
          state            <= S_IDLE;
          if (pending) begin
            // An absolute request replaces this frame's step and leaves velocity alone.
            x_out   <= req_cx.val[10:0];
            y_out   <= req_cy.val[9:0];
            pending <= 1'b0;
          end else begin
            x_out <= cx.val[10:0];
            y_out <= cy.val[9:0];
`ifdef SPRITE_BOUNCE_EN
            if (cx.hit) dx <= -dx;
            if (cy.hit) dy <= -dy;
`else
            if (cx.hit) dx <= '0;
            if (cy.hit) dy <= '0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
      // Accept after the commit clear so a request landing in COMMIT waits a frame.
      if (req_valid_in && req_ready_out) begin
        pending <= 1'b1;
        px      <= req_x_in;
        py      <= req_y_in;
      end
      // A host velocity write takes priority over a same-cycle bounce/zero.
      if (vel_valid_in) begin
        dx <= vel_dx_in;
        dy <= vel_dy_in;
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: reset, stepping, clamping, request timing, bounce, mid-frame reset.
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_x;
  logic [9:0]  req_y;
  logic        vel_valid;
  logic [3:0]  vel_dx, vel_dy;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        fu;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_motion_ctrl #(.WIDTH(256), .HEIGHT(256), .X_INIT(100), .Y_INIT(100)) dut (
    .pixel_clk_in     (clk),
    .rst_in           (rst),
    .hcount_in        (hcount),
    .vcount_in        (vcount),
    .req_valid_in     (req_valid),
    .req_ready_out    (req_ready),
    .req_x_in         (req_x),
    .req_y_in         (req_y),
    .vel_valid_in     (vel_valid),
    .vel_dx_in        (vel_dx),
    .vel_dy_in        (vel_dy),
    .x_out            (x_out),
    .y_out            (y_out),
    .frame_update_out (fu)
  );

  always #5 clk = ~clk;

  task automatic set_vel(input logic [3:0] ddx, input logic [3:0] ddy);
    @(negedge clk);
    vel_valid = 1'b1; vel_dx = ddx; vel_dy = ddy;
    @(negedge clk);
    vel_valid = 1'b0;
  endtask

  task automatic send_req(input logic [10:0] rx, input logic [9:0] ry, input string nm);
    @(negedge clk);
    req_valid = 1'b1; req_x = rx; req_y = ry;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++; $display("FAIL %s ready_after_accept got=%b exp=0", nm, req_ready);
    end
  endtask

  // Drives one frame edge (cycle E) and checks E+1..E+5; optionally presents a request in COMMIT.
  task automatic do_frame(input logic [10:0] ex, input logic [9:0] ey, input string nm,
                          input bit req_at_commit = 1'b0,
                          input logic [10:0] rx = '0, input logic [9:0] ry = '0);
    logic [10:0] ox;
    logic [9:0]  oy;
    ox = x_out; oy = y_out;
    @(negedge clk);
    hcount = 11'd0; vcount = 10'd720;
    @(posedge clk); #1;
    hcount = 11'd5; vcount = 10'd100;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (fu !== 1'b0 || x_out !== ox || y_out !== oy) begin
        n_bad++;
        $display("FAIL %s early_cycle%0d got fu=%b x=%0d y=%0d exp fu=0 x=%0d y=%0d",
                 nm, k, fu, x_out, y_out, ox, oy);
      end
      if (k == 3 && req_at_commit) begin
        req_valid = 1'b1; req_x = rx; req_y = ry;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (fu !== 1'b1 || x_out !== ex || y_out !== ey) begin
      n_bad++;
      $display("FAIL %s commit got fu=%b x=%0d y=%0d exp fu=1 x=%0d y=%0d",
               nm, fu, x_out, y_out, ex, ey);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (fu !== 1'b0) begin
      n_bad++; $display("FAIL %s pulse_width got fu=%b exp=0", nm, fu);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hcount = 11'd5; vcount = 10'd100;
    req_valid = 1'b0; req_x = '0; req_y = '0;
    vel_valid = 1'b0; vel_dx = '0; vel_dy = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (x_out !== 11'd100 || y_out !== 10'd100 || req_ready !== 1'b0 || fu !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold got x=%0d y=%0d rdy=%b fu=%b exp x=100 y=100 rdy=0 fu=0",
               x_out, y_out, req_ready, fu);
    end
    @(negedge clk); rst = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_ready_early got=%b exp=0", req_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || fu !== 1'b0 || x_out !== 11'd100 || y_out !== 10'd100) begin
      n_bad++;
      $display("FAIL reset_release got rdy=%b fu=%b x=%0d y=%0d exp rdy=1 fu=0 x=100 y=100",
               req_ready, fu, x_out, y_out);
    end
  endtask

  task automatic test_velocity();
    set_vel(4'd3, 4'b1110);
    do_frame(11'd103, 10'd98, "vel_f1");
    do_frame(11'd106, 10'd96, "vel_f2");
  endtask

  task automatic test_request_clamp();
    set_vel(4'd0, 4'd0);
    send_req(11'd2000, 10'd900, "req_clamp");
    do_frame(11'd1024, 10'd464, "req_clamp");
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL req_clamp ready_after_commit got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_req_in_commit();
    do_frame(11'd1024, 10'd464, "req_in_commit_f1", 1'b1, 11'd500, 10'd300);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++; $display("FAIL req_in_commit pending got rdy=%b exp=0", req_ready);
    end
    do_frame(11'd500, 10'd300, "req_in_commit_f2");
  endtask

  task automatic test_bounce();
    send_req(11'd1020, 10'd300, "bounce_setup");
    do_frame(11'd1020, 10'd300, "bounce_setup");
    set_vel(4'd7, 4'd0);
    do_frame(11'd1024, 10'd300, "bounce_clamp");
`ifdef SPRITE_BOUNCE_EN
    do_frame(11'd1017, 10'd300, "bounce_after");
`else
    do_frame(11'd1024, 10'd300, "bounce_after");
`endif
  endtask

  task automatic test_reset_mid();
    set_vel(4'b1011, 4'd2);
    @(negedge clk);
    hcount = 11'd0; vcount = 10'd720;
    @(posedge clk); #1;                 // E
    hcount = 11'd5; vcount = 10'd100;
    @(posedge clk); #1;                 // STEP
    @(posedge clk); #1;                 // CLAMP
    rst = 1'b1;
    #1;
    n_cmp++;
    if (x_out !== 11'd100 || y_out !== 10'd100 || fu !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_assert got x=%0d y=%0d fu=%b exp x=100 y=100 fu=0", x_out, y_out, fu);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (fu !== 1'b0 || x_out !== 11'd100 || y_out !== 10'd100) begin
        n_bad++;
        $display("FAIL reset_mid_after%0d got fu=%b x=%0d y=%0d exp fu=0 x=100 y=100",
                 k, fu, x_out, y_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_velocity();
    test_request_clamp();
    test_req_in_commit();
    test_bounce();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
